// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle integer divider.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Restoring radix-2 signed/unsigned divider returning {remainder, quotient}.
// Latency: 33 edges after the start-sampling edge (2 edges for a zero divisor).
// Backpressure: requester holds start_i until ready_o; dropping start_i or annul_i aborts.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               op1_neg_q, op1_neg_d;
    logic               op2_neg_q, op2_neg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   op1_mag, op2_mag;
    logic [WIDTH-1:0]   quot_mag, rem_mag;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic               op1_neg_in, op2_neg_in;

    // Bit WIDTH of the trial is the borrow: set means the divisor did not fit.
    assign trial = dividend_q[2*WIDTH:WIDTH] - {1'b0, divisor_q};

    assign op1_neg_in = signed_div_i & opdata1_i[WIDTH-1];
    assign op2_neg_in = signed_div_i & opdata2_i[WIDTH-1];
    assign op1_mag    = op1_neg_in ? -opdata1_i : opdata1_i;
    assign op2_mag    = op2_neg_in ? -opdata2_i : opdata2_i;

    assign quot_mag = dividend_q[WIDTH-1:0];
    assign rem_mag  = dividend_q[2*WIDTH:WIDTH+1];
    // Truncating division: remainder takes the dividend's sign.
    assign quot_fix = (op1_neg_q ^ op2_neg_q) ? -quot_mag : quot_mag;
    assign rem_fix  = op1_neg_q ? -rem_mag : rem_mag;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        op1_neg_d  = op1_neg_q;
        op2_neg_d  = op2_neg_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DIV_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d    = DIV_ON;
                        cnt_d      = '0;
                        op1_neg_d  = op1_neg_in;
                        op2_neg_d  = op2_neg_in;
                        divisor_d  = op2_mag;
                        dividend_d = {{WIDTH{1'b0}}, op1_mag, 1'b0};
                    end
                end
            end
            DIV_BY_ZERO: begin
                if (annul_i || !start_i) begin
                    state_d = DIV_FREE;
                end else begin
                    state_d  = DIV_END;
                    result_d = '0;
                end
            end
            DIV_ON: begin
                if (annul_i || !start_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                    cnt_d    = '0;
                end else if (cnt_q != CNT_W'(WIDTH)) begin
                    if (trial[WIDTH]) begin
                        dividend_d = {dividend_q[2*WIDTH-1:0], 1'b0};
                    end else begin
                        dividend_d = {trial[WIDTH-1:0], dividend_q[WIDTH-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = DIV_END;
                end
            end
            DIV_END: begin
                if (!start_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            op1_neg_q  <= 1'b0;
            op2_neg_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            op1_neg_q  <= op1_neg_d;
            op2_neg_q  <= op2_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at start, compared when ready_o rises.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input logic [63:0] exp);
        @(negedge clk);
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        annul      = 1'b0;
        start      = 1'b1;
        sb.push_back(exp);
    endtask

    // Edge 0 samples start; ready must stay low until edge 'lat'.
    task automatic wait_result(input string tag, input int lat);
        logic [63:0] e;
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk);
            #1;
            if (k < lat) begin
                chk({tag, "_busy"}, {63'b0, ready}, 64'd0);
            end else begin
                chk({tag, "_ready"}, {63'b0, ready}, 64'd1);
                if (sb.size() == 0) begin
                    chk({tag, "_sb_empty"}, 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk({tag, "_res"}, result, e);
                end
            end
        end
    endtask

    task automatic stop_op(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_drop_rdy"}, {63'b0, ready}, 64'd0);
        chk({tag, "_drop_res"}, result, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] dummy;
        rst        = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", {63'b0, ready}, 64'd0);
        chk("reset_res", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1: unsigned 100/7, then annul while in END must not clear
        start_op(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E);
        wait_result("u100_7", 33);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        chk("end_annul_rdy", {63'b0, ready}, 64'd1);
        chk("end_annul_res", result, 64'h00000002_0000000E);
        @(negedge clk);
        annul = 1'b0;
        stop_op("u100_7");

        // 2: signed sign combinations
        start_op(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD);
        wait_result("s_m7_2", 33);
        stop_op("s_m7_2");
        start_op(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD);
        wait_result("s_7_m2", 33);
        stop_op("s_7_m2");

        // 3: divide by zero
        start_op(32'h12345678, 32'd0, 1'b0, 64'd0);
        wait_result("byzero", 2);
        stop_op("byzero");

        // 4: annul at iteration 10, then an immediate new start
        start_op(32'hFFFFFFFF, 32'd3, 1'b0, 64'h00000000_55555555);
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            #1;
            chk("annul_busy", {63'b0, ready}, 64'd0);
        end
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        chk("annul_rdy", {63'b0, ready}, 64'd0);
        chk("annul_res", result, 64'd0);
        dummy = sb.pop_front();
        start_op(32'd50, 32'd5, 1'b0, 64'h00000000_0000000A);
        wait_result("u50_5", 33);
        stop_op("u50_5");

        // 5: reset at iteration 20
        start_op(32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D);
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk);
            #1;
            chk("rst_busy", {63'b0, ready}, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_rdy", {63'b0, ready}, 64'd0);
        chk("midrst_res", result, 64'd0);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        dummy = sb.pop_front();
        start_op(32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D);
        wait_result("u1000_3", 33);
        stop_op("u1000_3");

        // 6: signed overflow wrap and unsigned max / 1
        start_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000);
        wait_result("s_ovf", 33);
        stop_op("s_ovf");
        start_op(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF);
        wait_result("u_max_1", 33);
        stop_op("u_max_1");

        // Signed remainder with both operands negative: -100 / -7 = 14 r -2
        start_op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 64'hFFFFFFFE_0000000E);
        wait_result("s_m100_m7", 33);
        stop_op("s_m100_m7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
